// File: rtl/wiphy_pkg.sv
// Shared types and default widths for the wireless PHY receive path.
package wiphy_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEARCH  = 2'd1,
    CAPTURE = 2'd2,
    HOLDOFF = 2'd3
  } rx_seq_state_t;

  localparam int DATA_W_DEF = 32;
  localparam int LEN_W_DEF  = 16;
  localparam int TMO_W_DEF  = 24;

endpackage

// File: rtl/rx_timer.sv
// Loadable down-counter with zero flag; serves both search timeout and holdoff.
module rx_timer #(
  parameter int W = 24
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = val_i;
    end else if (dec_i && cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/rx_sequencer.sv
// Receive sequencer: arms the sync detector, captures one frame of ADC
// samples onto an AXI-Stream master, then holds off and re-arms.
module rx_sequencer
  import wiphy_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int LEN_W  = LEN_W_DEF,
  parameter int TMO_W  = TMO_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_enable,
  input  logic              cfg_oneshot,
  input  logic [LEN_W-1:0]  cfg_capture_len,
  input  logic [TMO_W-1:0]  cfg_timeout,
  input  logic [LEN_W-1:0]  cfg_holdoff,
  input  logic              clear_status,
  output logic              det_enable,
  input  logic              det_last,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              m_axis_tvalid,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tlast,
  input  logic              m_axis_tready,
  output rx_seq_state_t     state,
  output logic [LEN_W-1:0]  frame_count,
  output logic              sts_done,
  output logic              sts_timeout,
  output logic              sts_overflow,
  output logic              irq
);

  localparam int TW = (TMO_W > LEN_W) ? TMO_W : LEN_W;

  rx_seq_state_t     state_q, state_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic              tmo_en_q, tmo_en_d;
  logic [LEN_W-1:0]  frame_q, frame_d;
  logic              done_q, done_d;
  logic              tmo_q, tmo_d;
  logic              ovf_q, ovf_d;
  logic              irq_q, irq_d;
  logic              tv_q, tv_d;
  logic              tl_q, tl_d;
  logic [DATA_W-1:0] td_q, td_d;

  logic          tmr_load, tmr_dec, tmr_zero;
  logic [TW-1:0] tmr_val, tmo_m1, hold_m1;
  logic          frame_done, timeout_hit;
  logic          capt_fire, out_free, ovf_set;

  // Timer is loaded with N-1 so the zero flag marks the Nth cycle.
  assign tmo_m1  = TW'(cfg_timeout) - TW'(1);
  assign hold_m1 = (cfg_holdoff == '0) ? '0
                 : TW'(cfg_holdoff) - TW'(1);
  assign tmr_dec = (state_q == SEARCH) || (state_q == HOLDOFF);

  rx_timer #(.W(TW)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .load_i (tmr_load),
    .val_i  (tmr_val),
    .dec_i  (tmr_dec),
    .zero_o (tmr_zero)
  );

  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    tmo_en_d    = tmo_en_q;
    tmr_load    = 1'b0;
    tmr_val     = '0;
    frame_done  = 1'b0;
    timeout_hit = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cfg_enable) begin
          state_d  = SEARCH;
          tmr_load = 1'b1;
          tmr_val  = tmo_m1;
          tmo_en_d = (cfg_timeout != '0);
        end
      end
      SEARCH: begin
        if (det_last) begin
          state_d = CAPTURE;
          rem_d   = (cfg_capture_len == '0) ? LEN_W'(1)
                  : cfg_capture_len;
        end else if (tmo_en_q && tmr_zero) begin
          state_d     = IDLE;
          timeout_hit = 1'b1;
        end else if (!cfg_enable) begin
          state_d = IDLE;
        end
      end
      CAPTURE: begin
        if (s_valid) begin
          rem_d = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) begin
            state_d    = HOLDOFF;
            frame_done = 1'b1;
            tmr_load   = 1'b1;
            tmr_val    = hold_m1;
          end
        end
      end
      HOLDOFF: begin
        if (tmr_zero) begin
          if (cfg_enable && !cfg_oneshot) begin
            state_d  = SEARCH;
            tmr_load = 1'b1;
            tmr_val  = tmo_m1;
            tmo_en_d = (cfg_timeout != '0);
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign capt_fire = (state_q == CAPTURE) && s_valid;
  assign out_free  = !tv_q || m_axis_tready;

  // A strobe that finds the register still full is lost, not queued.
  always_comb begin
    tv_d    = tv_q;
    td_d    = td_q;
    tl_d    = tl_q;
    ovf_set = 1'b0;
    if (capt_fire && out_free) begin
      tv_d = 1'b1;
      td_d = s_data;
      tl_d = (rem_q == LEN_W'(1));
    end else begin
      ovf_set = capt_fire;
      if (tv_q && m_axis_tready) begin
        tv_d = 1'b0;
        tl_d = 1'b0;
      end
    end
  end

  assign frame_d = frame_q + LEN_W'(frame_done);
  assign done_d  = frame_done  | (done_q & ~clear_status);
  assign tmo_d   = timeout_hit | (tmo_q & ~clear_status);
  assign ovf_d   = ovf_set     | (ovf_q & ~clear_status);
  assign irq_d   = frame_done  | timeout_hit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      rem_q    <= '0;
      tmo_en_q <= 1'b0;
      frame_q  <= '0;
      done_q   <= 1'b0;
      tmo_q    <= 1'b0;
      ovf_q    <= 1'b0;
      irq_q    <= 1'b0;
      tv_q     <= 1'b0;
      tl_q     <= 1'b0;
      td_q     <= '0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      tmo_en_q <= tmo_en_d;
      frame_q  <= frame_d;
      done_q   <= done_d;
      tmo_q    <= tmo_d;
      ovf_q    <= ovf_d;
      irq_q    <= irq_d;
      tv_q     <= tv_d;
      tl_q     <= tl_d;
      td_q     <= td_d;
    end
  end

  assign state         = state_q;
  assign det_enable    = (state_q == SEARCH);
  assign m_axis_tvalid = tv_q;
  assign m_axis_tdata  = td_q;
  assign m_axis_tlast  = tl_q;
  assign frame_count   = frame_q;
  assign sts_done      = done_q;
  assign sts_timeout   = tmo_q;
  assign sts_overflow  = ovf_q;
  assign irq           = irq_q;

endmodule

// File: tb/tb_rx_sequencer.sv
// Randomized scoreboard bench for rx_sequencer with a frame-level model.
module tb_rx_sequencer;
  import wiphy_pkg::*;

  localparam int DW = 32;
  localparam int LW = 4;
  localparam int TW = 8;

  typedef struct packed {
    logic          last;
    logic [DW-1:0] data;
  } beat_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          cfg_enable, cfg_oneshot, clear_status;
  logic [LW-1:0] cfg_capture_len, cfg_holdoff;
  logic [TW-1:0] cfg_timeout;
  logic          det_enable, det_last, s_valid;
  logic [DW-1:0] s_data, tdata;
  logic          tvalid, tlast, tready;
  rx_seq_state_t st;
  logic [LW-1:0] frame_count;
  logic          sts_done, sts_timeout, sts_overflow, irq;

  int checks = 0;
  int failures = 0;
  int irq_seen = 0;
  int irq_exp = 0;
  int frame_exp = 0;
  logic irq_prev = 1'b0;
  beat_t exp_q[$];

  rx_sequencer #(.DATA_W(DW), .LEN_W(LW), .TMO_W(TW)) dut (
    .clk             (clk),
    .reset           (reset),
    .cfg_enable      (cfg_enable),
    .cfg_oneshot     (cfg_oneshot),
    .cfg_capture_len (cfg_capture_len),
    .cfg_timeout     (cfg_timeout),
    .cfg_holdoff     (cfg_holdoff),
    .clear_status    (clear_status),
    .det_enable      (det_enable),
    .det_last        (det_last),
    .s_valid         (s_valid),
    .s_data          (s_data),
    .m_axis_tvalid   (tvalid),
    .m_axis_tdata    (tdata),
    .m_axis_tlast    (tlast),
    .m_axis_tready   (tready),
    .state           (st),
    .frame_count     (frame_count),
    .sts_done        (sts_done),
    .sts_timeout     (sts_timeout),
    .sts_overflow    (sts_overflow),
    .irq             (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_st(input rx_seq_state_t s, input int bound);
    int n = 0;
    while (st != s && n < bound) begin
      cyc();
      n++;
    end
    chk("wait_state", st, s);
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (tvalid && tready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL beat_unexpected actual=%0h required=none", tdata);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          chk("beat_data", tdata, e.data);
          chk("beat_last", tlast, e.last);
        end
      end
      if (irq) begin
        irq_seen++;
        chk("irq_width", irq_prev, 0);
      end
      irq_prev = irq;
    end else begin
      irq_prev = 1'b0;
    end
  end

  task automatic run_frame(input int len, input int hold,
                           input bit drop, input rx_seq_state_t exp_end);
    int eff, effh, k, n, g;
    logic [DW-1:0] d;
    bit v;
    eff  = (len == 0) ? 1 : len;
    effh = (hold == 0) ? 1 : hold;
    wait_st(SEARCH, 20);
    chk("det_enable_search", det_enable, 1);
    cfg_capture_len = LW'(len);
    cfg_holdoff     = LW'(hold);
    det_last = 1'b1;
    s_valid  = 1'($urandom % 2);
    s_data   = $urandom;
    cyc();
    det_last = 1'b0;
    chk("enter_capture", st, CAPTURE);
    if (drop) cfg_enable = 1'b0;
    k = 0;
    g = 0;
    while (k < eff && g < 200) begin
      v = ($urandom % 4) != 0;
      d = $urandom;
      s_valid = v;
      s_data  = d;
      if (v) begin
        exp_q.push_back({(k == eff - 1), d});
        k++;
      end
      cyc();
      g++;
    end
    n = 0;
    while (st == HOLDOFF && n < 20) begin
      n++;
      s_valid = 1'($urandom % 2);
      s_data  = $urandom;
      cyc();
    end
    s_valid = 1'b0;
    frame_exp++;
    irq_exp++;
    chk("holdoff_cycles", n, effh);
    chk("end_state", st, exp_end);
    chk("det_enable_end", det_enable, (exp_end == SEARCH));
    chk("frame_count", frame_count, frame_exp % 16);
    chk("sts_done", sts_done, 1);
    chk("irq_count", irq_seen, irq_exp);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    logic [DW-1:0] d;
    reset = 1'b1;
    cfg_enable = 0; cfg_oneshot = 0; clear_status = 0;
    cfg_capture_len = '0; cfg_holdoff = '0; cfg_timeout = '0;
    det_last = 0; s_valid = 0; s_data = '0; tready = 1'b1;
    cyc();
    chk("rst_state", st, IDLE);
    chk("rst_tvalid", tvalid, 0);
    chk("rst_frame", frame_count, 0);
    chk("rst_sts", {sts_done, sts_timeout, sts_overflow, irq}, 0);
    chk("rst_det_en", det_enable, 0);
    cyc();
    reset = 1'b0;
    cyc();

    // Random frames, continuous ready; frame counter wraps past 15.
    for (int i = 0; i < 18; i++) begin
      bit drop;
      drop = ($urandom % 4) == 0;
      if (!cfg_enable) cfg_enable = 1'b1;
      run_frame($urandom_range(0, 6), $urandom_range(0, 3), drop,
                drop ? IDLE : SEARCH);
    end

    // Search timeout, including the shortest non-zero value.
    for (int i = 0; i < 2; i++) begin
      int n;
      t = (i == 0) ? 1 : $urandom_range(2, 20);
      cfg_enable = 1'b0;
      wait_st(IDLE, 5);
      cfg_timeout = TW'(t);
      cfg_enable = 1'b1;
      cyc();
      n = 0;
      while (st == SEARCH && n < 100) begin
        n++;
        cyc();
      end
      cfg_enable = 1'b0;
      irq_exp++;
      chk("timeout_cycles", n, t);
      chk("timeout_state", st, IDLE);
      chk("sts_timeout", sts_timeout, 1);
      cyc();
      chk("timeout_irq", irq_seen, irq_exp);
    end

    // One-shot frame returns to IDLE.
    cfg_timeout = '0;
    cfg_oneshot = 1'b1;
    cfg_enable  = 1'b1;
    run_frame(2, $urandom_range(0, 3), 0, IDLE);
    cfg_enable  = 1'b0;
    cfg_oneshot = 1'b0;
    cyc();

    // Stalled output: first sample held, the rest dropped.
    tready = 1'b0;
    cfg_capture_len = 3;
    cfg_holdoff = 1;
    cfg_enable = 1'b1;
    cyc();
    chk("ovf_search", st, SEARCH);
    det_last = 1'b1;
    cyc();
    det_last = 1'b0;
    for (int j = 0; j < 3; j++) begin
      d = $urandom;
      s_valid = 1'b1;
      s_data = d;
      if (j == 0) exp_q.push_back({1'b0, d});
      cyc();
    end
    s_valid = 1'b0;
    chk("ovf_state", st, HOLDOFF);
    chk("ovf_flag", sts_overflow, 1);
    chk("ovf_tvalid", tvalid, 1);
    chk("ovf_tlast", tlast, 0);
    cyc();
    tready = 1'b1;
    cyc();
    chk("ovf_drained", tvalid, 0);
    frame_exp++;
    irq_exp++;
    clear_status = 1'b1;
    cyc();
    clear_status = 1'b0;
    chk("clr_overflow", sts_overflow, 0);
    chk("clr_done", sts_done, 0);
    chk("clr_timeout", sts_timeout, 0);
    cfg_enable = 1'b0;
    wait_st(IDLE, 5);

    // Detection on the expiry cycle wins over timeout.
    cfg_capture_len = 1;
    cfg_holdoff = 1;
    cfg_timeout = 5;
    cfg_enable = 1'b1;
    repeat (5) cyc();
    chk("coin_search", st, SEARCH);
    det_last = 1'b1;
    cyc();
    det_last = 1'b0;
    chk("coin_capture", st, CAPTURE);
    chk("coin_no_tmo", sts_timeout, 0);
    d = $urandom;
    s_valid = 1'b1;
    s_data = d;
    exp_q.push_back({1'b1, d});
    cyc();
    s_valid = 1'b0;
    chk("coin_holdoff", st, HOLDOFF);
    cyc();
    chk("coin_rearm", st, SEARCH);
    cfg_enable = 1'b0;
    frame_exp++;
    irq_exp++;
    cyc();
    chk("coin_irq", irq_seen, irq_exp);
    chk("coin_frames", frame_count, frame_exp % 16);
    chk("coin_tmo_after", sts_timeout, 0);

    // Asynchronous reset in the middle of a capture.
    cfg_timeout = '0;
    cfg_capture_len = 4;
    tready = 1'b0;
    cfg_enable = 1'b1;
    cyc();
    det_last = 1'b1;
    cyc();
    det_last = 1'b0;
    s_valid = 1'b1;
    s_data = $urandom;
    cyc();
    s_valid = 1'b0;
    chk("pre_rst_tvalid", tvalid, 1);
    chk("pre_rst_state", st, CAPTURE);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_state", st, IDLE);
    chk("arst_tvalid", tvalid, 0);
    chk("arst_tdata", tdata, 0);
    chk("arst_misc",
        {tlast, det_enable, sts_done, sts_timeout, sts_overflow, irq}, 0);
    chk("arst_frames", frame_count, 0);
    cfg_enable = 1'b0;
    frame_exp = 0;
    tready = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
    cyc();
    chk("post_rst_state", st, IDLE);
    chk("post_rst_tvalid", tvalid, 0);

    chk("scoreboard_empty", exp_q.size(), 0);
    chk("irq_total", irq_seen, irq_exp);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
